// File: rtl/ps2_command_assembler.sv
// PS2 scancode stream to ASCII command words: make/break/extended decoding,
// optional repeat suppression, backspace, Enter-to-commit and a small command FIFO.
module ps2_command_assembler #(
   parameter int CHARS     = 4,
   parameter int DEPTH     = 2,
   parameter int REPEAT_EN = 0,
   localparam int LW       = $clog2(CHARS + 1)
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 key_valid,
   input  logic [7:0]           key_data,
   input  logic                 cmd_ack,
   output logic                 cmd_valid,
   output logic [CHARS*8-1:0]   cmd_word,
   output logic [LW-1:0]        cmd_len,
   output logic [CHARS*8-1:0]   cur_word,
   output logic [LW-1:0]        cur_len,
   output logic                 char_ovf,
   output logic                 cmd_ovf
);

   localparam int WW = CHARS * 8;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = $clog2(DEPTH + 1);

   localparam logic [1:0] S_MAKE      = 2'd0;
   localparam logic [1:0] S_BREAK     = 2'd1;
   localparam logic [1:0] S_EXT       = 2'd2;
   localparam logic [1:0] S_EXT_BREAK = 2'd3;

   localparam logic [LW-1:0] FULL_LEN = LW'(CHARS);
   localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [1:0]    state;
   logic [7:0]    last_make;
   logic [WW-1:0] mem_word [DEPTH];
   logic [LW-1:0] mem_len  [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [NW-1:0] count;

   logic       is_make, accept, is_char, is_bs, is_enter;
   logic       fifo_full, do_push, do_pop;
   logic [7:0] ascii;

   // Set-2 make code to ASCII; 0 means not a printable key.
   function automatic logic [7:0] map_key(input logic [7:0] code);
      case (code)
         8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
         8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
         8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
         8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
         8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
         8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
         8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
         8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
         8'h35: return 8'h59;  8'h1A: return 8'h5A;
         8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
         8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
         8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
         8'h46: return 8'h39;  8'h29: return 8'h20;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      is_make   = key_valid && (state == S_MAKE) && (key_data != 8'hF0) && (key_data != 8'hE0);
      accept    = is_make && ((REPEAT_EN != 0) || (key_data != last_make));
      ascii     = map_key(key_data);
      is_char   = accept && (ascii != 8'h00);
      is_bs     = accept && (key_data == 8'h66);
      is_enter  = accept && (key_data == 8'h5A);
      fifo_full = (count == FULL_CNT);
      cmd_valid = (count != '0);
      // A same-cycle ack does not make room for the push.
      do_push   = is_enter && (cur_len != '0) && !fifo_full;
      do_pop    = cmd_valid && cmd_ack;
      cmd_word  = cmd_valid ? mem_word[rd_ptr] : '0;
      cmd_len   = cmd_valid ? mem_len[rd_ptr]  : '0;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state     <= S_MAKE;
         last_make <= '0;
         cur_word  <= '0;
         cur_len   <= '0;
         char_ovf  <= 1'b0;
         cmd_ovf   <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
      end else begin
         char_ovf <= 1'b0;

         if (do_push) begin
            mem_word[wr_ptr] <= cur_word;
            mem_len[wr_ptr]  <= cur_len;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (do_pop)
            rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)
            count <= count + NW'(1);
         else if (!do_push && do_pop)
            count <= count - NW'(1);

         if (is_char) begin
            if (cur_len != FULL_LEN) begin
               cur_word <= (cur_word << 8) | WW'(ascii);
               cur_len  <= cur_len + LW'(1);
            end else begin
               char_ovf <= 1'b1;
            end
         end else if (is_bs && (cur_len != '0)) begin
            cur_word <= cur_word >> 8;
            cur_len  <= cur_len - LW'(1);
         end else if (is_enter && (cur_len != '0)) begin
            if (do_push) begin
               cur_word <= '0;
               cur_len  <= '0;
            end else begin
               cmd_ovf <= 1'b1;
            end
         end

         if (accept)
            last_make <= key_data;
         else if (key_valid && (state == S_BREAK) && (key_data == last_make))
            last_make <= '0;

         if (key_valid) begin
            case (state)
               S_MAKE: begin
                  if (key_data == 8'hF0)
                     state <= S_BREAK;
                  else if (key_data == 8'hE0)
                     state <= S_EXT;
               end
               S_EXT:   state <= (key_data == 8'hF0) ? S_EXT_BREAK : S_MAKE;
               default: state <= S_MAKE;
            endcase
         end
      end
   end

endmodule
